// File: rtl/spy_write_ctrl.sv
// Write-side controller for the circular spy memory: records accepted FIFO words,
// freezes a programmable number of events after a request, and muxes in block writes.
module spy_write_ctrl #(
    parameter int DATAWIDTH   = 64,
    parameter int MEMWIDTH    = 6,
    parameter int POST_EVENTS = 2
) (
    input  logic                  clock,
    input  logic                  resetbar,
    input  logic                  write_enable,
    input  logic [DATAWIDTH:0]    write_data,
    input  logic                  freeze,
    input  logic                  unfreeze,
    input  logic [1:0]            playback,
    input  logic                  ram_write_enable,
    input  logic [DATAWIDTH:0]    ram_write_data,
    output logic                  spy_write_enable,
    output logic [DATAWIDTH:0]    spy_write_data,
    output logic [MEMWIDTH-1:0]   spy_write_addr,
    output logic                  frozen,
    output logic                  armed,
    output logic                  wrapped
);

    localparam logic [1:0] NO_PLAYBACK    = 2'd0;
    localparam logic [1:0] PLAYBACK_ONCE  = 2'd1;
    localparam logic [1:0] PLAYBACK_LOOP  = 2'd2;
    localparam logic [1:0] PLAYBACK_WRITE = 2'd3;
    localparam logic [7:0] POST_CNT       = 8'(POST_EVENTS);

    typedef enum logic [1:0] {RECORD, ARMED, FROZEN} state_t;

    state_t                state_q, state_d, state_cur;
    logic [7:0]            cnt_q, cnt_d, cnt_left;
    logic [MEMWIDTH-1:0]   addr_q, addr_d;
    logic [DATAWIDTH:0]    data_q, data_d;
    logic                  we_q, we_d;
    logic                  wrapped_q, wrapped_d;
    logic                  written_q, written_d;
    logic                  frozen_q, armed_q;
    logic [1:0]            prev_mode_q;
    logic                  enter_blk, leave_blk, marker;

    always_comb begin
        enter_blk = (playback == PLAYBACK_WRITE) && (prev_mode_q != PLAYBACK_WRITE);
        leave_blk = (playback != PLAYBACK_WRITE) && (prev_mode_q == PLAYBACK_WRITE);
        // Block-loaded data must survive until an explicit unfreeze.
        state_cur = leave_blk ? FROZEN : state_q;
        marker    = write_data[DATAWIDTH];
        cnt_left  = POST_CNT - 8'(write_enable && marker);

        state_d   = state_cur;
        cnt_d     = leave_blk ? 8'd0 : cnt_q;
        we_d      = 1'b0;
        data_d    = data_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        written_d = written_q;

        case (playback)
            NO_PLAYBACK: begin
                case (state_cur)
                    RECORD: begin
                        if (freeze && !unfreeze) begin
                            if (POST_EVENTS == 0) begin
                                state_d = FROZEN;
                            end else begin
                                we_d    = write_enable;
                                cnt_d   = cnt_left;
                                state_d = (cnt_left == 8'd0) ? FROZEN : ARMED;
                            end
                        end else begin
                            we_d = write_enable;
                        end
                    end
                    ARMED: begin
                        we_d = write_enable;
                        if (unfreeze) begin
                            state_d = RECORD;
                            cnt_d   = 8'd0;
                        end else if (write_enable && marker) begin
                            if (cnt_q == 8'd1) begin
                                state_d = FROZEN;
                                cnt_d   = 8'd0;
                            end else begin
                                cnt_d = cnt_q - 8'd1;
                            end
                        end
                    end
                    FROZEN: begin
                        if (unfreeze) begin
                            state_d = RECORD;
                            cnt_d   = 8'd0;
                        end
                    end
                    default: state_d = RECORD;
                endcase
                if (we_d) data_d = write_data;
            end
            PLAYBACK_WRITE: begin
                if (enter_blk) begin
                    addr_d    = '1;
                    written_d = 1'b0;
                    wrapped_d = 1'b0;
                end else begin
                    we_d = ram_write_enable;
                    if (ram_write_enable) data_d = ram_write_data;
                end
            end
            PLAYBACK_ONCE, PLAYBACK_LOOP: begin
                we_d = 1'b0;
            end
            default: we_d = 1'b0;
        endcase

        if (we_d) begin
            addr_d    = addr_q + 1'b1;
            written_d = 1'b1;
            if ((addr_q == '1) && written_q) wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetbar) begin
        if (!resetbar) begin
            state_q     <= RECORD;
            cnt_q       <= 8'd0;
            addr_q      <= '1;
            data_q      <= '0;
            we_q        <= 1'b0;
            wrapped_q   <= 1'b0;
            written_q   <= 1'b0;
            frozen_q    <= 1'b0;
            armed_q     <= 1'b0;
            prev_mode_q <= NO_PLAYBACK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            wrapped_q   <= wrapped_d;
            written_q   <= written_d;
            frozen_q    <= (state_d == FROZEN);
            armed_q     <= (state_d == ARMED);
            prev_mode_q <= playback;
        end
    end

    assign spy_write_enable = we_q;
    assign spy_write_data   = data_q;
    assign spy_write_addr   = addr_q;
    assign frozen           = frozen_q;
    assign armed            = armed_q;
    assign wrapped          = wrapped_q;

endmodule

// File: tb/tb_spy_write_ctrl.sv
// Bench for spy_write_ctrl: two instances (POST_EVENTS=2 and 0) share stimulus and are
// compared every cycle against a transaction-level model.
module tb_spy_write_ctrl;

    localparam int DW    = 8;
    localparam int MW    = 3;
    localparam int DEPTH = 8;
    localparam int REC   = 0;
    localparam int ARM   = 1;
    localparam int FRZ   = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          resetbar, write_enable, freeze, unfreeze, ram_write_enable;
    logic [DW:0]   write_data, ram_write_data;
    logic [1:0]    playback;
    logic [1:0]    o_we, o_frozen, o_armed, o_wrapped;
    logic [MW-1:0] o_addr [2];
    logic [DW:0]   o_data [2];

    spy_write_ctrl #(.DATAWIDTH(DW), .MEMWIDTH(MW), .POST_EVENTS(2)) u_dut_post2 (
        .clock(clock), .resetbar(resetbar), .write_enable(write_enable),
        .write_data(write_data), .freeze(freeze), .unfreeze(unfreeze),
        .playback(playback), .ram_write_enable(ram_write_enable),
        .ram_write_data(ram_write_data), .spy_write_enable(o_we[0]),
        .spy_write_data(o_data[0]), .spy_write_addr(o_addr[0]),
        .frozen(o_frozen[0]), .armed(o_armed[0]), .wrapped(o_wrapped[0])
    );

    spy_write_ctrl #(.DATAWIDTH(DW), .MEMWIDTH(MW), .POST_EVENTS(0)) u_dut_post0 (
        .clock(clock), .resetbar(resetbar), .write_enable(write_enable),
        .write_data(write_data), .freeze(freeze), .unfreeze(unfreeze),
        .playback(playback), .ram_write_enable(ram_write_enable),
        .ram_write_data(ram_write_data), .spy_write_enable(o_we[1]),
        .spy_write_data(o_data[1]), .spy_write_addr(o_addr[1]),
        .frozen(o_frozen[1]), .armed(o_armed[1]), .wrapped(o_wrapped[1])
    );

    int          post_events [2] = '{2, 0};
    int          m_state [2];
    int          m_cnt [2];
    int          m_ptr [2];
    int          m_prev [2];
    bit          m_written [2];
    bit          m_wrapped [2];
    bit          m_we [2];
    logic [DW:0] m_data [2];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k]   = REC;
            m_cnt[k]     = 0;
            m_ptr[k]     = DEPTH - 1;
            m_prev[k]    = 0;
            m_written[k] = 1'b0;
            m_wrapped[k] = 1'b0;
            m_we[k]      = 1'b0;
            m_data[k]    = '0;
        end
    endtask

    // One clock of input for instance k; leaves the expectation for the next cycle.
    task automatic model_step(input int k, input bit we, input logic [DW:0] wd, input bit fr,
                              input bit uf, input int pb, input bit rwe, input logic [DW:0] rwd);
        bit wr;
        int st;
        int left;
        wr = 1'b0;
        st = m_state[k];
        if (m_prev[k] == 3 && pb != 3) begin
            st = FRZ;
            m_cnt[k] = 0;
        end
        if (pb == 3) begin
            if (m_prev[k] != 3) begin
                m_ptr[k] = DEPTH - 1;
                m_written[k] = 1'b0;
                m_wrapped[k] = 1'b0;
            end else if (rwe) begin
                wr = 1'b1;
                m_data[k] = rwd;
            end
        end else if (pb == 0) begin
            if (uf && st != REC) begin
                wr = we && (st == ARM);
                st = REC;
                m_cnt[k] = 0;
            end else if (st == FRZ) begin
                wr = 1'b0;
            end else if (st == REC && fr && !uf) begin
                if (post_events[k] == 0) begin
                    st = FRZ;
                end else begin
                    wr = we;
                    left = post_events[k] - ((we && wd[DW]) ? 1 : 0);
                    m_cnt[k] = left;
                    st = (left == 0) ? FRZ : ARM;
                end
            end else begin
                wr = we;
                if (st == ARM && we && wd[DW]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) st = FRZ;
                end
            end
            if (wr) m_data[k] = wd;
        end
        m_state[k] = st;
        if (wr) begin
            if (m_ptr[k] == DEPTH - 1 && m_written[k]) m_wrapped[k] = 1'b1;
            m_written[k] = 1'b1;
            m_ptr[k] = (m_ptr[k] + 1) % DEPTH;
        end
        m_we[k] = wr;
        m_prev[k] = pb;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("we%0d", k), 64'(o_we[k]), 64'(m_we[k]));
            check($sformatf("addr%0d", k), 64'(o_addr[k]), 64'(m_ptr[k]));
            check($sformatf("data%0d", k), 64'(o_data[k]), 64'(m_data[k]));
            check($sformatf("wrapped%0d", k), 64'(o_wrapped[k]), 64'(m_wrapped[k]));
            check($sformatf("frozen%0d", k), 64'(o_frozen[k]), 64'(m_state[k] == FRZ));
            check($sformatf("armed%0d", k), 64'(o_armed[k]), 64'(m_state[k] == ARM));
        end
    endtask

    task automatic cyc(input bit we, input logic [DW:0] wd, input bit fr, input bit uf,
                       input logic [1:0] pb, input bit rwe, input logic [DW:0] rwd);
        write_enable     = we;
        write_data       = wd;
        freeze           = fr;
        unfreeze         = uf;
        playback         = pb;
        ram_write_enable = rwe;
        ram_write_data   = rwd;
        for (int k = 0; k < 2; k++) model_step(k, we, wd, fr, uf, int'(pb), rwe, rwd);
        @(posedge clock);
        #1;
        compare_all();
        $display("t=%0t pb=%0d we=%0b wd=%03h fr=%0b uf=%0b rwe=%0b | p2 we=%0b addr=%0d frz=%0b arm=%0b wrp=%0b | p0 we=%0b addr=%0d frz=%0b",
                 $time, pb, we, wd, fr, uf, rwe, o_we[0], o_addr[0], o_frozen[0], o_armed[0],
                 o_wrapped[0], o_we[1], o_addr[1], o_frozen[1]);
        write_enable     = 1'b0;
        freeze           = 1'b0;
        unfreeze         = 1'b0;
        ram_write_enable = 1'b0;
    endtask

    initial begin
        logic [DW:0] wd;
        bit          mk [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  pb;

        resetbar = 1'b0; write_enable = 1'b0; write_data = '0; freeze = 1'b0;
        unfreeze = 1'b0; playback = 2'd0; ram_write_enable = 1'b0; ram_write_data = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        resetbar = 1'b1;
        cyc(0, '0, 0, 0, 2'd0, 0, '0);

        // Sequential fill with wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 9'(i), 0, 0, 2'd0, 0, '0);
            check("fill_addr", 64'(o_addr[0]), 64'(i % DEPTH));
            check("fill_wrapped", 64'(o_wrapped[0]), 64'(i >= 8));
        end
        cyc(0, '0, 0, 0, 2'd0, 0, '0);
        check("fill_final_addr", 64'(o_addr[0]), 64'd1);

        // Post-event freeze (instance 0) vs immediate freeze (instance 1).
        cyc(0, '0, 1, 0, 2'd0, 0, '0);
        check("imm_frozen", 64'(o_frozen[1]), 64'd1);
        check("pe_armed", 64'(o_armed[0]), 64'd1);
        for (int j = 0; j < 5; j++) begin
            wd = {mk[j], 8'(8'h20 + j)};
            cyc(1, wd, 0, 0, 2'd0, 0, '0);
            check("pe_armed_seq", 64'(o_armed[0]), 64'(j < 3));
            check("pe_frozen_seq", 64'(o_frozen[0]), 64'(j >= 3));
        end
        check("pe_addr", 64'(o_addr[0]), 64'd5);
        check("imm_addr", 64'(o_addr[1]), 64'd1);

        // Unfreeze, then freeze with a same-cycle word.
        cyc(0, '0, 0, 1, 2'd0, 0, '0);
        cyc(1, 9'h033, 1, 0, 2'd0, 0, '0);
        check("imm_nowrite", 64'(o_we[1]), 64'd0);
        check("imm_frozen2", 64'(o_frozen[1]), 64'd1);
        check("armed_write", 64'(o_addr[0]), 64'd6);

        // Playback hold.
        for (int j = 0; j < 8; j++) begin
            cyc(j[0], 9'($urandom_range(0, 511)), j == 2, j == 5, 2'd2, 0, '0);
            check("hold_addr0", 64'(o_addr[0]), 64'd6);
            check("hold_addr1", 64'(o_addr[1]), 64'd1);
            check("hold_frozen1", 64'(o_frozen[1]), 64'd1);
        end

        // Block write.
        cyc(0, '0, 0, 0, 2'd3, 1, 9'h0FF);
        check("blk_entry_addr", 64'(o_addr[0]), 64'd7);
        for (int j = 0; j < 5; j++) begin
            cyc(0, '0, 0, 0, 2'd3, 1, 9'(9'h140 + j));
            check("blk_addr", 64'(o_addr[0]), 64'(j));
        end
        cyc(1, 9'h011, 0, 0, 2'd0, 0, '0);
        check("blk_final_addr", 64'(o_addr[0]), 64'd4);
        check("blk_frozen", 64'(o_frozen[0]), 64'd1);
        check("blk_wrapped", 64'(o_wrapped[0]), 64'd0);
        cyc(0, '0, 0, 1, 2'd0, 0, '0);
        cyc(1, 9'h055, 0, 0, 2'd0, 0, '0);
        check("blk_resume", 64'(o_addr[0]), 64'd5);

        // Asynchronous reset with ARMED count and write in flight.
        cyc(0, '0, 1, 0, 2'd0, 0, '0);
        cyc(1, 9'h066, 0, 0, 2'd0, 0, '0);
        #3;
        resetbar = 1'b0;
        #1;
        check("rst_we", 64'(o_we[0]), 64'd0);
        check("rst_addr", 64'(o_addr[0]), 64'd7);
        check("rst_armed", 64'(o_armed[0]), 64'd0);
        check("rst_frozen1", 64'(o_frozen[1]), 64'd0);
        check("rst_data", 64'(o_data[0]), 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        resetbar = 1'b1;
        cyc(1, 9'h077, 1, 1, 2'd0, 0, '0);
        check("fu_armed", 64'(o_armed[0]), 64'd0);
        check("fu_frozen1", 64'(o_frozen[1]), 64'd0);

        // Randomized traffic.
        pb = 2'd0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                pb = 2'($urandom_range(0, 5) > 3 ? 0 : $urandom_range(0, 3));
            end
            wd = {($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))};
            cyc($urandom_range(0, 9) < 6, wd, $urandom_range(0, 14) == 0,
                $urandom_range(0, 24) == 0, pb, $urandom_range(0, 1) == 1,
                9'($urandom_range(0, 511)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spy_write_ctrl.md
Name: spy_write_ctrl

Overview:
- Write-side controller for the spy memory. Records every word accepted into the flow-control FIFO into the circular spy memory, and freezes recording a programmable number of events after a freeze request.
- Sits directly upstream of the spy playback controller: produces spy_write_addr, which playback uses as its stop/loop address.
- Muxes block-write traffic from playback (PLAYBACK_WRITE mode) onto the single memory write port.

Parameters:
- DATAWIDTH, 64, data width excluding the metadata bit; bit DATAWIDTH of every word is the end-of-event marker.
- MEMWIDTH, 6, spy memory address width; depth = 2**MEMWIDTH.
- POST_EVENTS, 2, number of end-of-event words still recorded after a freeze request; 0 freezes immediately. Must be < 256.

Ports:
- clock  input  1  system clock.
- resetbar  input  1  asynchronous, active-low reset.
- write_enable  input  1  word accepted into the flow-control FIFO this cycle.
- write_data  input  DATAWIDTH+1  accepted word; MSB is the end-of-event marker.
- freeze  input  1  single-cycle freeze request.
- unfreeze  input  1  single-cycle request to resume recording.
- playback  input  2  playback mode; encodings from SpyProtocol.vh.
- ram_write_enable  input  1  block-write strobe from the playback controller.
- ram_write_data  input  DATAWIDTH+1  block-write word from the playback controller.
- spy_write_enable  output  1  memory write strobe.
- spy_write_data  output  DATAWIDTH+1  memory write data.
- spy_write_addr  output  MEMWIDTH  write address while spy_write_enable=1; otherwise the address of the last word written.
- frozen  output  1  state == FROZEN.
- armed  output  1  state == ARMED.
- wrapped  output  1  memory has been overwritten at least once since reset or block-write entry.

Behaviour:
- Reset (async, resetbar=0):
  - state=RECORD; spy_write_addr=2**MEMWIDTH-1 (all ones); spy_write_enable=0; spy_write_data=0; wrapped=0; event counter=0.
  - Internal flag written=0.
- All outputs are registered. A qualifying input in cycle N produces spy_write_enable=1 in cycle N+1, with spy_write_addr = previous value + 1 (mod 2**MEMWIDTH). The address wraps from all ones to 0. spy_write_addr holds whenever no write occurs.
- Wrap detection: a write issued while spy_write_addr is all ones and written=1 sets wrapped. Every write sets written.
- Source select by playback mode:
  - NO_PLAYBACK: the data path is the source and the state machine runs.
  - PLAYBACK_ONCE / PLAYBACK_LOOP: no writes are issued; write_enable is ignored; state, counter and pointer hold; freeze and unfreeze are ignored.
  - PLAYBACK_WRITE: the source is ram_write_enable/ram_write_data, regardless of state.
- Entering PLAYBACK_WRITE from any other mode: on the first cycle in that mode, spy_write_addr=all ones, written=0, wrapped=0, and no write is issued. This makes block writes start at address 0.
- Leaving PLAYBACK_WRITE: pointer is retained, so playback stops at the last block-written word. State is forced to FROZEN, so recording does not overwrite the loaded data until unfreeze.
- State machine (NO_PLAYBACK only):
  - RECORD: every write_enable issues a write.
    - freeze with POST_EVENTS=0 -> FROZEN; a word presented in the same cycle is NOT written.
    - freeze with POST_EVENTS>0 -> ARMED, counter=POST_EVENTS; a same-cycle word IS written and counts if its marker is set.
  - ARMED: every write_enable issues a write; each written word with marker=1 decrements the counter.
    - When a marker word is written with counter==1 -> FROZEN after that write.
    - A repeated freeze is ignored.
  - FROZEN: write_enable is ignored; pointer holds.
  - unfreeze in ARMED or FROZEN -> RECORD; counter cleared; pointer and wrapped retained. A word in the same cycle as unfreeze is written only if the state was ARMED.
  - freeze and unfreeze in the same cycle: unfreeze wins.
- Reset mid-operation clears everything asynchronously, including a pending ARMED count and any in-flight write strobe.

Test Plan:
- Sequential fill (MEMWIDTH=3, NO_PLAYBACK): reset, then 10 consecutive words 0..9.
  - Writes land at addresses 0..7, then 0, 1.
  - wrapped rises on the write of word 8.
  - Final spy_write_addr=1; spy_write_enable one cycle after each write_enable.
- Post-event freeze (POST_EVENTS=2): freeze, then words with markers 0,1,0,1,0.
  - armed=1 until the 4th word is written, then frozen=1.
  - 5th word not written; spy_write_addr = address of word 4.
- Immediate freeze (POST_EVENTS=0): freeze with write_enable in the same cycle.
  - No write; frozen=1 next cycle; pointer unchanged.
- Playback hold: from FROZEN, playback=PLAYBACK_LOOP with write_enable toggling and freeze/unfreeze pulsed.
  - No writes; frozen stays 1; pointer stable.
- Block write: enter PLAYBACK_WRITE, 5 ram_write_enable pulses, then playback=NO_PLAYBACK.
  - Addresses 0..4 written with ram_write_data; wrapped=0.
  - spy_write_addr=4; frozen=1.
  - unfreeze then resumes recording at address 5.
- Async reset: assert resetbar=0 mid-ARMED with a write in flight.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Concurrent freeze+unfreeze after reset leaves state RECORD.
